// File: rtl/ahb_apb_bridge_p3.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_bridge_p3
//  Purpose  : AHB slave to APB3 master bridge. One AHB transfer at a time is
//             decoded into one of NUM_SLV equally sized address regions and
//             replayed as an APB3 SETUP/ACCESS sequence. Supports PREADY wait
//             states, PSLVERR propagation, AHB ERROR on decode miss and an
//             optional PREADY-low timeout.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   bridge clock
//    resetn     in   asynchronous active-low reset
//    Hwrite     in   AHB write (address phase)
//    Hreadyin   in   AHB bus ready
//    Htrans     in   AHB transfer type (only Htrans[1] matters)
//    Haddr      in   AHB address
//    Hwdata     in   AHB write data (data phase)
//    Hrdata     out  AHB read data, holds last read value
//    Hresp      out  AHB response, 00 OKAY / 01 ERROR
//    Hreadyout  out  bridge ready
//    Pselx      out  one-hot APB select
//    Penable    out  APB enable
//    Pwrite     out  APB write
//    Paddr      out  APB address (full Haddr)
//    Pwdata     out  APB write data
//    Prdata     in   APB read data (externally muxed)
//    Pready     in   APB3 ready
//    Pslverr    in   APB3 slave error
// ============================================================================
module ahb_apb_bridge_p3 #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE        = 32'h8000_0000,
  parameter int                REGION_LOG2 = 26,
  parameter int                MAX_WAIT    = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout,
  output logic [NUM_SLV-1:0] Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  // A zero-width counter is illegal, so MAX_WAIT=0 still gets one bit.
  localparam int                CNT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] NUM_SLV_A = ADDR_W'(NUM_SLV);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WWAIT  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_SLV-1:0] sel_pend, sel_pend_nxt;
  logic [NUM_SLV-1:0] sel_dec;
  logic [ADDR_W-1:0]  off, idx;
  logic               addr_ok;
  logic               sample;
  logic               timeout;

  logic               hready_nxt;
  logic [1:0]         hresp_nxt;
  logic [DATA_W-1:0]  hrdata_nxt;
  logic [NUM_SLV-1:0] psel_nxt;
  logic               penable_nxt;
  logic               pwrite_nxt;
  logic [ADDR_W-1:0]  paddr_nxt;
  logic [DATA_W-1:0]  pwdata_nxt;

  // SEQ vs NONSEQ is irrelevant to a bridge that handles one beat at a time.
  logic unused_htrans0;
  assign unused_htrans0 = Htrans[0];

  // --------------------------------------------------------------------------
  // Address decode: region index relative to BASE, valid only above BASE and
  // inside the populated slave range.
  // --------------------------------------------------------------------------
  assign off     = Haddr - BASE;
  assign idx     = off >> REGION_LOG2;
  assign addr_ok = (Haddr >= BASE) && (idx < NUM_SLV_A);

  generate
    for (genvar g = 0; g < NUM_SLV; g++) begin : g_dec
      assign sel_dec[g] = (idx == ADDR_W'(g));
    end
  endgenerate

  // Hreadyout is 1 in both IDLE and ERR2, the only states that accept a
  // new address phase.
  assign sample  = Hreadyin && Hreadyout && Htrans[1] &&
                   ((state == S_IDLE) || (state == S_ERR2));

  assign timeout = (MAX_WAIT > 0) && (cnt == CNT_MAX);

  // --------------------------------------------------------------------------
  // State and output registers. Every output is a flop; the combinational
  // block below computes their next values.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel_pend  <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= RESP_OKAY;
      Hrdata    <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel_pend  <= sel_pend_nxt;
      Hreadyout <= hready_nxt;
      Hresp     <= hresp_nxt;
      Hrdata    <= hrdata_nxt;
      Pselx     <= psel_nxt;
      Penable   <= penable_nxt;
      Pwrite    <= pwrite_nxt;
      Paddr     <= paddr_nxt;
      Pwdata    <= pwdata_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_pend_nxt = sel_pend;
    hready_nxt   = Hreadyout;
    hresp_nxt    = Hresp;
    hrdata_nxt   = Hrdata;
    psel_nxt     = Pselx;
    penable_nxt  = Penable;
    pwrite_nxt   = Pwrite;
    paddr_nxt    = Paddr;
    pwdata_nxt   = Pwdata;

    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt   = S_IDLE;
        hready_nxt  = 1'b1;
        hresp_nxt   = RESP_OKAY;
        psel_nxt    = '0;
        penable_nxt = 1'b0;
        if (sample) begin
          hready_nxt = 1'b0;
          if (addr_ok) begin
            paddr_nxt    = Haddr;
            pwrite_nxt   = Hwrite;
            sel_pend_nxt = sel_dec;
            if (Hwrite) begin
              // Write data arrives one cycle later; hold off the select.
              state_nxt = S_WWAIT;
            end else begin
              state_nxt = S_SETUP;
              psel_nxt  = sel_dec;
              cnt_nxt   = '0;
            end
          end else begin
            state_nxt = S_ERR1;
            hresp_nxt = RESP_ERR;
          end
        end
      end

      S_WWAIT: begin
        state_nxt  = S_SETUP;
        pwdata_nxt = Hwdata;
        psel_nxt   = sel_pend;
        cnt_nxt    = '0;
      end

      S_SETUP: begin
        state_nxt   = S_ACCESS;
        penable_nxt = 1'b1;
      end

      S_ACCESS: begin
        if (Pready) begin
          psel_nxt    = '0;
          penable_nxt = 1'b0;
          if (Pslverr) begin
            state_nxt = S_ERR1;
            hresp_nxt = RESP_ERR;
          end else begin
            state_nxt  = S_IDLE;
            hready_nxt = 1'b1;
            if (!Pwrite) begin
              hrdata_nxt = Prdata;
            end
          end
        end else if (timeout) begin
          state_nxt   = S_ERR1;
          hresp_nxt   = RESP_ERR;
          psel_nxt    = '0;
          penable_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_ERR1: begin
        state_nxt  = S_ERR2;
        hready_nxt = 1'b1;
        hresp_nxt  = RESP_ERR;
      end

      default: begin
        state_nxt   = S_IDLE;
        hready_nxt  = 1'b1;
        hresp_nxt   = RESP_OKAY;
        psel_nxt    = '0;
        penable_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
